bitty_fetch_seq: RTL and testbench

- Instruction sequencer for the bitty core: owns the program counter, reads 16-bit instructions from a synchronous-read instruction memory, and issues them to the core via the run/d_instr/done handshake.
- Resolves conditional branches internally against the core's last ALU result (d_out).
- Counts retired instructions and guards against a hung core with a watchdog.
- Sits between instruction ROM/RAM and the bitty core at the top level.

---
 rtl/bitty_fetch_seq_if.sv | 31 +++
 rtl/bitty_fetch_seq.sv | 184 ++++++++++++++++++
 tb/tb_bitty_fetch_seq.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/bitty_fetch_seq_if.sv
// Bundles the instruction-memory bus, the core run/done handshake and the
// control/status signals of the bitty fetch sequencer.
interface bitty_fetch_seq_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] start_pc;
  logic              halt_req;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_rd_data;
  logic              run;
  logic [15:0]       d_instr;
  logic              done;
  logic [15:0]       d_out;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              halted;
  logic              err;
  logic [15:0]       instr_count;

  modport master (
    input  start, start_pc, halt_req, mem_rd_data, done, d_out,
    output mem_rd_en, mem_addr, run, d_instr, pc, busy, halted, err, instr_count
  );

  modport slave (
    output start, start_pc, halt_req, mem_rd_data, done, d_out,
    input  mem_rd_en, mem_addr, run, d_instr, pc, busy, halted, err, instr_count
  );
endinterface

// File: rtl/bitty_fetch_seq.sv
// Instruction sequencer for the bitty core: fetches from synchronous-read
// memory, resolves branches locally, issues the rest to the core, and watchdogs it.
module bitty_fetch_seq #(
  parameter int          ADDR_W     = 8,
  parameter logic [15:0] HALT_INSTR = 16'hFFFF,
  parameter int          TIMEOUT    = 64
) (
  input logic               clk,
  input logic               reset,
  bitty_fetch_seq_if.master bus
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  localparam logic [ADDR_W-1:0] PC_INC  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PC_ZERO = {ADDR_W{1'b0}};
  localparam logic [WD_W-1:0]   WD_INC  = {{(WD_W-1){1'b0}}, 1'b1};
  localparam logic [WD_W-1:0]   WD_ZERO = {WD_W{1'b0}};
  localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_MEM    = 3'd2,
    S_EXEC   = 3'd3,
    S_BRANCH = 3'd4,
    S_HALT   = 3'd5,
    S_ERROR  = 3'd6
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              halt_q, halt_d;
  logic              run_q, run_d;
  logic [15:0]       d_instr_q, d_instr_d;
  logic              rd_en_q, rd_en_d;
  logic              busy_q, busy_d;
  logic              halted_q, halted_d;
  logic              err_q, err_d;

  logic              busy_s;
  logic              halt_pend_s;
  logic              taken_s;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    cnt_d     = cnt_q;
    wd_d      = wd_q;
    halt_d    = halt_q;
    d_instr_d = d_instr_q;

    busy_s = (state_q == S_FETCH) || (state_q == S_MEM) ||
             (state_q == S_EXEC)  || (state_q == S_BRANCH);
    // A stop request arriving in the very cycle an instruction retires still counts
    halt_pend_s = halt_q || (bus.halt_req && busy_s);

    case (ir_q[3:2])
      2'b00:   taken_s = (bus.d_out == 16'h0000);
      2'b01:   taken_s = (bus.d_out != 16'h0000);
      2'b10:   taken_s = 1'b1;
      2'b11:   taken_s = bus.d_out[15];
      default: taken_s = 1'b0;
    endcase

    case (state_q)
      S_IDLE, S_HALT: begin
        if (bus.start) begin
          pc_d    = bus.start_pc;
          cnt_d   = 16'h0000;
          state_d = S_FETCH;
        end else begin
          state_d = state_q;
        end
      end
      S_FETCH: begin
        state_d = S_MEM;
      end
      S_MEM: begin
        ir_d = bus.mem_rd_data;
        wd_d = WD_ZERO;
        if (bus.mem_rd_data == HALT_INSTR) begin
          state_d = S_HALT;
        end else if (bus.mem_rd_data[1:0] == 2'b11) begin
          state_d = S_BRANCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (bus.done) begin
          pc_d    = pc_q + PC_INC;
          cnt_d   = cnt_q + 16'd1;
          wd_d    = WD_ZERO;
          state_d = halt_pend_s ? S_HALT : S_FETCH;
        end else if (wd_q == WD_LAST) begin
          wd_d    = wd_q + WD_INC;
          state_d = S_ERROR;
        end else begin
          wd_d    = wd_q + WD_INC;
        end
      end
      S_BRANCH: begin
        pc_d    = taken_s ? ADDR_W'(ir_q[15:4]) : (pc_q + PC_INC);
        cnt_d   = cnt_q + 16'd1;
        state_d = halt_pend_s ? S_HALT : S_FETCH;
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if ((state_d == S_HALT) || (state_d == S_IDLE)) begin
      halt_d = 1'b0;
    end else if (bus.halt_req && busy_s) begin
      halt_d = 1'b1;
    end else begin
      halt_d = halt_q;
    end

    // Outputs are registered from the next state so they line up with it
    if ((state_q == S_MEM) && (state_d == S_EXEC)) begin
      d_instr_d = ir_d;
    end else begin
      d_instr_d = d_instr_q;
    end
    run_d    = (state_d == S_EXEC);
    rd_en_d  = (state_d == S_FETCH);
    busy_d   = (state_d == S_FETCH) || (state_d == S_MEM) ||
               (state_d == S_EXEC)  || (state_d == S_BRANCH);
    halted_d = (state_d == S_HALT);
    err_d    = (state_d == S_ERROR);
  end

  // State, datapath and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= PC_ZERO;
      ir_q      <= 16'h0000;
      cnt_q     <= 16'h0000;
      wd_q      <= WD_ZERO;
      halt_q    <= 1'b0;
      run_q     <= 1'b0;
      d_instr_q <= 16'h0000;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      cnt_q     <= cnt_d;
      wd_q      <= wd_d;
      halt_q    <= halt_d;
      run_q     <= run_d;
      d_instr_q <= d_instr_d;
      rd_en_q   <= rd_en_d;
      busy_q    <= busy_d;
      halted_q  <= halted_d;
      err_q     <= err_d;
    end
  end

  assign bus.mem_rd_en   = rd_en_q;
  assign bus.mem_addr    = pc_q;
  assign bus.run         = run_q;
  assign bus.d_instr     = d_instr_q;
  assign bus.pc          = pc_q;
  assign bus.busy        = busy_q;
  assign bus.halted      = halted_q;
  assign bus.err         = err_q;
  assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_bitty_fetch_seq.sv
// Directed bench for bitty_fetch_seq: memory model, fetch/issue scoreboard
// with a negedge monitor, plus status checks at key points.
module tb_bitty_fetch_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;

  bitty_fetch_seq_if #(.ADDR_W(8)) bus ();

  bitty_fetch_seq #(
    .ADDR_W    (8),
    .HALT_INSTR(16'hFFFF),
    .TIMEOUT   (64)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [256];
  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0]  fetch_q [$];
  logic [15:0] issue_q [$];
  logic        run_prev = 1'b0;
  logic [7:0]  exp_addr;
  logic [15:0] exp_instr;

  always @(posedge clk) begin
    if (bus.mem_rd_en === 1'b1) bus.mem_rd_data <= mem[bus.mem_addr];
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Monitor: every fetch strobe and every run rising edge is matched against the queues
  always @(negedge clk) begin
    if (bus.mem_rd_en === 1'b1) begin
      if (fetch_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_fetch: mem_addr 0x%0h with none expected", bus.mem_addr);
      end else begin
        exp_addr = fetch_q.pop_front();
        check("fetch_addr", 32'(bus.mem_addr), 32'(exp_addr));
      end
    end
    if (bus.run === 1'b1 && run_prev === 1'b0) begin
      if (issue_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_issue: d_instr 0x%0h with none expected", bus.d_instr);
      end else begin
        exp_instr = issue_q.pop_front();
        check("issue_instr", 32'(bus.d_instr), 32'(exp_instr));
      end
    end
    run_prev <= bus.run;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_run(input string name);
    int n = 0;
    while (bus.run !== 1'b1 && n < 50) begin tick(1); n++; end
    check(name, 32'(bus.run), 32'h1);
  endtask

  task automatic wait_halted(input string name);
    int n = 0;
    while (bus.halted !== 1'b1 && n < 50) begin tick(1); n++; end
    check(name, 32'(bus.halted), 32'h1);
  endtask

  task automatic do_start(input logic [7:0] spc);
    bus.start_pc = spc;
    bus.start    = 1'b1;
    tick(1);
    bus.start    = 1'b0;
  endtask

  task automatic pulse_done_after(input int k);
    tick(k - 1);
    bus.done = 1'b1;
    tick(1);
    bus.done = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_pc"},     32'(bus.pc),          32'h0);
    check({tag, "_run"},    32'(bus.run),         32'h0);
    check({tag, "_dinstr"}, 32'(bus.d_instr),     32'h0);
    check({tag, "_rden"},   32'(bus.mem_rd_en),   32'h0);
    check({tag, "_addr"},   32'(bus.mem_addr),    32'h0);
    check({tag, "_busy"},   32'(bus.busy),        32'h0);
    check({tag, "_halted"}, 32'(bus.halted),      32'h0);
    check({tag, "_err"},    32'(bus.err),         32'h0);
    check({tag, "_count"},  32'(bus.instr_count), 32'h0);
  endtask

  // Branch vectors: start_pc, instruction, d_out, expected next pc
  typedef struct {
    logic [7:0]  spc;
    logic [15:0] instr;
    logic [15:0] dout;
    logic [7:0]  npc;
  } br_vec_t;

  br_vec_t br_tab [6] = '{
    '{8'h02, 16'h0503, 16'h0000, 8'h50},
    '{8'h02, 16'h0503, 16'h0005, 8'h03},
    '{8'h02, 16'h0507, 16'h0005, 8'h50},
    '{8'h02, 16'h050B, 16'h1234, 8'h50},
    '{8'h02, 16'h050F, 16'h8000, 8'h50},
    '{8'h02, 16'h050F, 16'h7FFF, 8'h03}
  };

  initial begin
    int cnt;
    for (int i = 0; i < 256; i++) mem[i] = 16'hFFFF;
    bus.start = 1'b0; bus.start_pc = 8'h00; bus.halt_req = 1'b0;
    bus.done = 1'b0; bus.d_out = 16'h0000;

    // Reset state
    tick(2);
    check_idle_zero("reset");
    reset = 1'b0;
    tick(1);

    // Basic issue then halt
    mem[8'h00] = 16'h1234; mem[8'h01] = 16'hFFFF;
    fetch_q.push_back(8'h00); issue_q.push_back(16'h1234); fetch_q.push_back(8'h01);
    do_start(8'h00);
    check("t1_rden_cycle1", 32'(bus.mem_rd_en), 32'h1);
    wait_run("t1_run");
    pulse_done_after(3);
    check("t1_run_fall", 32'(bus.run), 32'h0);
    check("t1_pc_after_done", 32'(bus.pc), 32'h1);
    wait_halted("t1_halted");
    check("t1_pc", 32'(bus.pc), 32'h1);
    check("t1_count", 32'(bus.instr_count), 32'h1);
    check("t1_busy", 32'(bus.busy), 32'h0);

    // Branch conditions
    mem[8'h50] = 16'hFFFF; mem[8'h03] = 16'hFFFF;
    foreach (br_tab[i]) begin
      mem[br_tab[i].spc] = br_tab[i].instr;
      bus.d_out = br_tab[i].dout;
      fetch_q.push_back(br_tab[i].spc); fetch_q.push_back(br_tab[i].npc);
      do_start(br_tab[i].spc);
      wait_halted("br_halted");
      check("br_pc", 32'(bus.pc), 32'(br_tab[i].npc));
      check("br_count", 32'(bus.instr_count), 32'h1);
    end

    // halt_req mid-EXEC
    mem[8'h20] = 16'h1111; mem[8'h21] = 16'h2222;
    fetch_q.push_back(8'h20); issue_q.push_back(16'h1111);
    do_start(8'h20);
    wait_run("hr_run");
    tick(1);
    bus.halt_req = 1'b1; tick(1); bus.halt_req = 1'b0;
    pulse_done_after(3);
    wait_halted("hr_halted");
    check("hr_pc", 32'(bus.pc), 32'h21);
    check("hr_count", 32'(bus.instr_count), 32'h1);
    tick(4);
    check("hr_still_halted", 32'(bus.halted), 32'h1);
    mem[8'h10] = 16'hFFFF;
    fetch_q.push_back(8'h10);
    do_start(8'h10);
    check("hr_restart_count", 32'(bus.instr_count), 32'h0);
    wait_halted("hr_restart_halted");
    check("hr_restart_pc", 32'(bus.pc), 32'h10);

    // pc wrap
    mem[8'hFF] = 16'h4444; mem[8'h00] = 16'hFFFF;
    fetch_q.push_back(8'hFF); issue_q.push_back(16'h4444); fetch_q.push_back(8'h00);
    do_start(8'hFF);
    wait_run("wrap_run");
    pulse_done_after(2);
    check("wrap_pc", 32'(bus.pc), 32'h0);
    wait_halted("wrap_halted");
    check("wrap_count", 32'(bus.instr_count), 32'h1);

    // Reset while run is high, after one retired instruction
    mem[8'h40] = 16'h5555; mem[8'h41] = 16'h6666;
    fetch_q.push_back(8'h40); issue_q.push_back(16'h5555);
    fetch_q.push_back(8'h41); issue_q.push_back(16'h6666);
    do_start(8'h40);
    wait_run("rr_run1");
    pulse_done_after(2);
    wait_run("rr_run2");
    check("rr_count_before", 32'(bus.instr_count), 32'h1);
    tick(1);
    reset = 1'b1; tick(1);
    check("rr_run", 32'(bus.run), 32'h0);
    check("rr_busy", 32'(bus.busy), 32'h0);
    check("rr_count", 32'(bus.instr_count), 32'h0);
    reset = 1'b0;
    bus.done = 1'b1; tick(1); bus.done = 1'b0;
    tick(3);
    check("rr_late_done_count", 32'(bus.instr_count), 32'h0);
    check("rr_late_done_pc", 32'(bus.pc), 32'h0);
    check("rr_late_done_busy", 32'(bus.busy), 32'h0);

    // Watchdog timeout
    mem[8'h30] = 16'h1230;
    fetch_q.push_back(8'h30); issue_q.push_back(16'h1230);
    do_start(8'h30);
    wait_run("wd_run");
    cnt = 0;
    while (bus.run === 1'b1 && cnt < 200) begin cnt++; tick(1); end
    check("wd_run_cycles", 32'(cnt), 32'd64);
    check("wd_err", 32'(bus.err), 32'h1);
    check("wd_busy", 32'(bus.busy), 32'h0);
    do_start(8'h00);
    tick(2);
    check("wd_start_ignored_err", 32'(bus.err), 32'h1);
    check("wd_start_ignored_busy", 32'(bus.busy), 32'h0);
    reset = 1'b1; tick(1);
    check_idle_zero("wd_reset");
    reset = 1'b0;
    tick(3);

    check("fetch_q_empty", 32'(fetch_q.size()), 32'h0);
    check("issue_q_empty", 32'(issue_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
